// File: rtl/apb_uart_core.sv
// UART 8N1 transmitter and receiver behind an APB-style select.
// TX starts on a write to TX_ADDR; RX runs continuously and exposes the last good byte.
module apb_uart_core #(
    parameter int         C       = 87,
    parameter logic [7:0] TX_ADDR = 8'h02,
    parameter logic [7:0] RX_ADDR = 8'h01
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic [7:0] PADDR,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    input  logic       rx_serial,
    output logic       tx_serial,
    output logic       tx_active,
    output logic       tx_done,
    output logic       rx_done,
    output logic [7:0] rx_data
);
    localparam int CW = (C > 2) ? $clog2(C) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(C - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((C - 1) / 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_e;

    state_e          tx_state_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [2:0]      tx_bit_q;
    logic [7:0]      tx_data_q;
    logic            tx_serial_q, tx_active_q, tx_done_q;

    state_e          rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q, rx_data_q;
    logic [1:0]      rx_sync_q;
    logic            rx_done_q;

    logic tx_start;
    logic rx_bit;

    assign tx_start = PSEL & PENABLE & PWRITE & (PADDR == TX_ADDR);
    assign rx_bit   = rx_sync_q[1];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state_q  <= S_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_data_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            case (tx_state_q)
                S_IDLE: begin
                    tx_serial_q <= 1'b1;
                    tx_done_q   <= 1'b0;
                    tx_cnt_q    <= '0;
                    tx_bit_q    <= '0;
                    if (tx_start) begin
                        tx_data_q   <= PWDATA;
                        tx_serial_q <= 1'b0;
                        tx_active_q <= 1'b1;
                        tx_state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q    <= '0;
                        tx_serial_q <= tx_data_q[0];
                        tx_state_q  <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_bit_q    <= '0;
                            tx_serial_q <= 1'b1;
                            tx_state_q  <= S_STOP;
                        end else begin
                            tx_bit_q    <= tx_bit_q + 3'd1;
                            tx_serial_q <= tx_data_q[tx_bit_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == CNT_LAST) begin
                        tx_cnt_q    <= '0;
                        tx_done_q   <= 1'b1;
                        tx_active_q <= 1'b0;
                        tx_state_q  <= S_CLEANUP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CW'(1);
                    end
                end
                S_CLEANUP: begin
                    tx_done_q  <= 1'b0;
                    tx_state_q <= S_IDLE;
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // Synchronizer resets high so a reset never looks like a start bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_serial};
            case (rx_state_q)
                S_IDLE: begin
                    rx_done_q <= 1'b0;
                    rx_cnt_q  <= '0;
                    rx_bit_q  <= '0;
                    if (!rx_bit) rx_state_q <= S_START;
                end
                S_START: begin
                    if (rx_cnt_q == CNT_MID) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= rx_bit ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_bit, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_bit_q   <= '0;
                            rx_state_q <= S_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == CNT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_CLEANUP;
                        if (rx_bit) begin
                            rx_data_q <= rx_shift_q;
                            rx_done_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CW'(1);
                    end
                end
                S_CLEANUP: begin
                    rx_done_q  <= 1'b0;
                    rx_state_q <= S_IDLE;
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;
    assign rx_done   = rx_done_q;
    assign rx_data   = rx_data_q;
    assign PRDATA    = (PSEL & ~PWRITE & (PADDR == RX_ADDR)) ? rx_data_q : 8'h00;
endmodule

// File: tb/tb_apb_uart_core.sv
// Bench for apb_uart_core with C=2: random bytes over loopback, compared to a
// frame-level model of the 8N1 line and the last-good-byte register.
module tb_apb_uart_core;
    localparam int C   = 2;
    localparam int FR  = 10 * C;
    localparam int PER = FR + 2;
    localparam logic [7:0] TXA = 8'h02;
    localparam logic [7:0] RXA = 8'h01;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA, PRDATA;
    logic       rx_serial, tx_serial, tx_active, tx_done, rx_done;
    logic [7:0] rx_data;
    logic       loop_en, rx_drv;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] model_rx;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    apb_uart_core #(.C(C), .TX_ADDR(TXA), .RX_ADDR(RXA)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .rx_serial(rx_serial), .tx_serial(tx_serial), .tx_active(tx_active),
        .tx_done(tx_done), .rx_done(rx_done), .rx_data(rx_data)
    );

    always #5 PCLK = ~PCLK;

    // Line level during bit slot k (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] d, input int k, input logic stop);
        if (k == 0) return 1'b0;
        if (k == 9) return stop;
        return d[k-1];
    endfunction

    task automatic bus_idle();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 8'h00; PWDATA = 8'h00;
    endtask

    task automatic hold_write(input logic [7:0] d);
        PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = TXA; PWDATA = d;
    endtask

    // Returns at the first falling edge after the start edge (frame cycle 0).
    task automatic apb_write(input logic [7:0] d);
        @(negedge PCLK);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = TXA; PWDATA = d;
        @(negedge PCLK);
        PENABLE = 1;
        @(negedge PCLK);
        bus_idle();
    endtask

    task automatic read_rx(output logic [7:0] v);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = RXA;
        #1 v = PRDATA;
        @(negedge PCLK);
        bus_idle();
    endtask

    // Observes the line from frame cycle 0; counts cycles whose tx outputs
    // differ from the model, plus tx_done / rx_done pulses.
    task automatic watch_frames(input logic [7:0] d, input int frames, input int poke_cyc,
                                input logic [7:0] poke_d, output int tx_err,
                                output int txd_cnt, output int rxd_cnt);
        logic exp_tx, exp_act, exp_done;
        int   ph;
        tx_err = 0; txd_cnt = 0; rxd_cnt = 0;
        for (int cyc = 0; cyc < frames * PER + 6; cyc++) begin
            ph       = cyc % PER;
            exp_tx   = 1'b1;
            exp_act  = 1'b0;
            exp_done = 1'b0;
            if (cyc < frames * PER) begin
                if (ph < FR) begin
                    exp_tx  = frame_bit(d, ph / C, 1'b1);
                    exp_act = 1'b1;
                end
                exp_done = (ph == FR);
            end
            if (tx_serial !== exp_tx || tx_active !== exp_act || tx_done !== exp_done)
                tx_err++;
            if (tx_done === 1'b1) txd_cnt++;
            if (rx_done === 1'b1) rxd_cnt++;
            if (cyc == poke_cyc) hold_write(poke_d);
            if (cyc == poke_cyc + 1 || cyc == frames * PER - 1) bus_idle();
            @(negedge PCLK);
        end
    endtask

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop, output int rxd_cnt);
        rxd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < C; j++) begin
                rx_drv = frame_bit(d, k, stop);
                @(negedge PCLK);
                if (rx_done === 1'b1) rxd_cnt++;
            end
        end
        rx_drv = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge PCLK);
            if (rx_done === 1'b1) rxd_cnt++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        PRESETn = 0; loop_en = 0; rx_drv = 1; bus_idle();
        repeat (3) @(negedge PCLK);
        n_checks++;
        if ({tx_serial, tx_active, tx_done, rx_done} !== 4'b1000)
            $display("FAIL reset_in: tx/act/done/rxd=%b want 1000", {tx_serial, tx_active, tx_done, rx_done});
        else n_pass++;
        PRESETn = 1;
        repeat (4) @(negedge PCLK);
        n_checks++;
        if ({tx_serial, tx_active, tx_done, rx_done} !== 4'b1000)
            $display("FAIL reset_out: tx/act/done/rxd=%b want 1000", {tx_serial, tx_active, tx_done, rx_done});
        else n_pass++;
        n_checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data);
        else n_pass++;
        read_rx(v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL reset_prdata: got %h want 00", v);
        else n_pass++;
        model_rx = 8'h00;
    endtask

    task automatic test_loopback(input logic [7:0] d, input string tag);
        int e, t, r;
        logic [7:0] v;
        loop_en = 1;
        apb_write(d);
        watch_frames(d, 1, -10, 8'h00, e, t, r);
        model_rx = d;
        n_checks++;
        if (e != 0) $display("FAIL %s_tx_wave: %0d bad cycles want 0 (byte %h)", tag, e, d);
        else n_pass++;
        n_checks++;
        if (t != 1 || r != 1) $display("FAIL %s_pulses: tx_done=%0d rx_done=%0d want 1 1", tag, t, r);
        else n_pass++;
        read_rx(v);
        n_checks++;
        if (v !== model_rx || rx_data !== model_rx)
            $display("FAIL %s_rx: PRDATA=%h rx_data=%h want %h", tag, v, rx_data, model_rx);
        else n_pass++;
    endtask

    task automatic test_prdata_decode();
        PSEL = 1; PWRITE = 1; PADDR = RXA;
        #1;
        n_checks++;
        if (PRDATA !== 8'h00) $display("FAIL prdata_write: got %h want 00", PRDATA);
        else n_pass++;
        PWRITE = 0; PADDR = 8'h03;
        #1;
        n_checks++;
        if (PRDATA !== 8'h00) $display("FAIL prdata_addr: got %h want 00", PRDATA);
        else n_pass++;
        PSEL = 0; PADDR = RXA;
        #1;
        n_checks++;
        if (PRDATA !== 8'h00) $display("FAIL prdata_nosel: got %h want 00", PRDATA);
        else n_pass++;
        @(negedge PCLK);
        bus_idle();
    endtask

    task automatic test_back_to_back();
        int e, t, r;
        loop_en = 1;
        @(negedge PCLK);
        hold_write(8'hAA);
        @(negedge PCLK);
        watch_frames(8'hAA, 3, -10, 8'h00, e, t, r);
        model_rx = 8'hAA;
        n_checks++;
        if (e != 0) $display("FAIL b2b_tx_wave: %0d bad cycles want 0", e);
        else n_pass++;
        n_checks++;
        if (t != 3 || r != 3) $display("FAIL b2b_pulses: tx_done=%0d rx_done=%0d want 3 3", t, r);
        else n_pass++;
    endtask

    task automatic test_ignore_midframe(input int poke_cyc, input string tag);
        int e, t, r;
        loop_en = 1;
        apb_write(8'hAA);
        watch_frames(8'hAA, 1, poke_cyc, 8'h55, e, t, r);
        model_rx = 8'hAA;
        n_checks++;
        if (e != 0 || t != 1) $display("FAIL %s_ignore: %0d bad cycles, tx_done=%0d want 0 1", tag, e, t);
        else n_pass++;
        n_checks++;
        if (rx_data !== model_rx) $display("FAIL %s_rx: got %h want %h", tag, rx_data, model_rx);
        else n_pass++;
    endtask

    task automatic test_rx_errors();
        int r;
        logic [7:0] d;
        loop_en = 0; rx_drv = 1;
        repeat (3) @(negedge PCLK);
        drive_rx_frame(8'h3C, 1'b0, r);
        n_checks++;
        if (r != 0 || rx_data !== model_rx)
            $display("FAIL framing_err: rx_done=%0d rx_data=%h want 0 %h", r, rx_data, model_rx);
        else n_pass++;
        rx_drv = 0;
        @(negedge PCLK);
        rx_drv = 1;
        r = 0;
        repeat (30) begin
            @(negedge PCLK);
            if (rx_done === 1'b1) r++;
        end
        n_checks++;
        if (r != 0 || rx_data !== model_rx)
            $display("FAIL glitch: rx_done=%0d rx_data=%h want 0 %h", r, rx_data, model_rx);
        else n_pass++;
        d = 8'($urandom_range(0, 255));
        drive_rx_frame(d, 1'b1, r);
        model_rx = d;
        n_checks++;
        if (r != 1 || rx_data !== model_rx)
            $display("FAIL rx_recover: rx_done=%0d rx_data=%h want 1 %h", r, rx_data, model_rx);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        int t, lows;
        loop_en = 1;
        apb_write(8'($urandom_range(0, 255)));
        repeat (6) @(negedge PCLK);
        PRESETn = 0;
        #1;
        model_rx = 8'h00;
        n_checks++;
        if (tx_serial !== 1'b1 || tx_active !== 1'b0)
            $display("FAIL rst_mid_abort: tx=%b act=%b want 1 0", tx_serial, tx_active);
        else n_pass++;
        t = 0; lows = 0;
        repeat (3) begin
            @(negedge PCLK);
            if (tx_done === 1'b1) t++;
        end
        PRESETn = 1;
        repeat (25) begin
            @(negedge PCLK);
            if (tx_done === 1'b1 || rx_done === 1'b1) t++;
            if (tx_serial !== 1'b1) lows++;
        end
        n_checks++;
        if (t != 0 || lows != 0 || rx_data !== model_rx)
            $display("FAIL rst_mid_quiet: done=%0d low=%0d rx_data=%h want 0 0 %h", t, lows, rx_data, model_rx);
        else n_pass++;
        test_loopback(8'($urandom_range(0, 255)), "post_rst");
    endtask

    initial begin
        test_reset();
        test_loopback(8'hAA, "aa");
        test_prdata_decode();
        for (int i = 0; i < 4; i++) test_loopback(8'($urandom_range(0, 255)), "rand");
        test_back_to_back();
        test_ignore_midframe(8, "mid");
        test_ignore_midframe(FR, "cleanup");
        test_rx_errors();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time exceeded, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
